// File: rtl/johnson_seq_ctrl.sv
// Round-counting sequencer around an N-bit Johnson counter with hold, abort and phase decode.
// Build macro JOHNSON_SELFCORRECT_EN adds illegal-Q recovery with an err strobe.
module johnson_seq_ctrl #(
  parameter int N  = 4,
  parameter int RW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           stop,
  input  logic           hold,
  input  logic [RW-1:0]  rounds,
  output logic [N-1:0]   Q,
  output logic [2*N-1:0] phase,
  output logic [1:0]     state,
  output logic           busy,
  output logic [RW-1:0]  round_cnt,
  output logic           done,
  output logic           aborted,
  output logic           err
);

`ifdef JOHNSON_SELFCORRECT_EN
  localparam bit self_correct_en = 1'b1;
`else
  localparam bit self_correct_en = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [N-1:0] LastState = {{(N-1){1'b0}}, 1'b1};

  state_e        state_q;
  logic [N-1:0]  q_q;
  logic [RW-1:0] cnt_q;
  logic [RW-1:0] rounds_q;
  logic          arm_q;
  logic          done_q;
  logic          aborted_q;
  logic          err_q;

  logic [N-1:0]  q_d;
  logic [RW-1:0] cnt_d;
  logic [N-1:0]  walk;
  logic          illegal_d;
  int            edges;

  function automatic logic [N-1:0] johnson_step(input logic [N-1:0] v);
    return {~v[0], v[N-1:1]};
  endfunction

  assign q_d   = johnson_step(q_q);
  assign cnt_d = cnt_q + RW'(1);

  // Walk the legal sequence from 0 and flag the position that matches Q.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    walk  = '0;
    phase = '0;
    for (int k = 0; k < 2*N; k++) begin
      // NOTE: blocking assignments here, because walk must update within this pass of the loop.
      phase[k] = (q_q == walk);
      walk     = johnson_step(walk);
    end
  end

  // A legal Johnson word has at most one boundary between its run of ones and its run of zeros.
  always_comb begin
    edges = 0;
    for (int i = 0; i < N-1; i++) begin
      if (q_q[i] != q_q[i+1]) edges++;
    end
    illegal_d = (edges > 1);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= ST_IDLE;
      q_q       <= '0;
      cnt_q     <= '0;
      rounds_q  <= '0;
      arm_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
      if (self_correct_en && illegal_d) begin
        q_q   <= '0;
        err_q <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start && !stop) begin
              state_q  <= ST_RUN;
              rounds_q <= rounds;
              cnt_q    <= '0;
              q_q      <= '0;
              arm_q    <= 1'b1;
            end
          end
          ST_RUN: begin
            if (stop) begin
              state_q   <= ST_IDLE;
              q_q       <= '0;
              cnt_q     <= '0;
              aborted_q <= 1'b1;
            end else if (hold) begin
              state_q <= ST_PAUSE;
            end else if (arm_q) begin
              arm_q <= 1'b0;
            end else begin
              q_q <= q_d;
              if (q_q == LastState) begin
                cnt_q <= cnt_d;
                if (rounds_q != '0 && cnt_d == rounds_q) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                end
              end
            end
          end
          ST_PAUSE: begin
            if (stop) begin
              state_q   <= ST_IDLE;
              q_q       <= '0;
              cnt_q     <= '0;
              aborted_q <= 1'b1;
            end else if (!hold) begin
              state_q <= ST_RUN;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign Q         = q_q;
  assign state     = state_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign round_cnt = cnt_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign err       = err_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Bench for johnson_seq_ctrl: directed steps plus random traffic against an index-based reference model.
module tb_johnson_seq_ctrl;

  localparam int N  = 4;
  localparam int RW = 8;

`ifdef JOHNSON_SELFCORRECT_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset, start, stop, hold;
  logic [RW-1:0]  rounds;
  logic [N-1:0]   Q;
  logic [2*N-1:0] phase;
  logic [1:0]     state;
  logic           busy, done, aborted, err;
  logic [RW-1:0]  round_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: sequence position index rather than a bit pattern.
  int          m_st, m_k, m_cnt, m_rounds;
  bit          m_arm, m_done, m_abort, m_err, m_raw;
  logic [N-1:0] m_rawq;

  johnson_seq_ctrl #(.N(N), .RW(RW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .hold(hold),
    .rounds(rounds), .Q(Q), .phase(phase), .state(state), .busy(busy),
    .round_cnt(round_cnt), .done(done), .aborted(aborted), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // k-th word of the sequence: k ones filling from the MSB, then k-N zeros filling from the MSB.
  function automatic logic [N-1:0] q_of(input int k);
    logic [N-1:0] v;
    int p;
    v = '0;
    for (int i = 0; i < N; i++) begin
      p = N - 1 - i;
      v[i] = (k <= N) ? (p < k) : (p >= k - N);
    end
    return v;
  endfunction

  function automatic bit legal(input logic [N-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < N-1; i++) if (v[i] != v[i+1]) c++;
    return c <= 1;
  endfunction

  function automatic logic [N-1:0] exp_q();
    return m_raw ? m_rawq : q_of(m_k);
  endfunction

  function automatic logic [2*N-1:0] exp_phase();
    logic [2*N-1:0] ph;
    ph = '0;
    if (!m_raw) ph[m_k] = 1'b1;
    return ph;
  endfunction

  task automatic abort_run();
    m_st = 0; m_k = 0; m_raw = 0; m_cnt = 0; m_abort = 1;
  endtask

  task automatic advance();
    if (m_raw) begin
      m_rawq = (m_rawq >> 1) | (N'(~m_rawq[0]) << (N-1));
    end else begin
      m_k = (m_k + 1) % (2*N);
      if (m_k == 0) begin
        m_cnt = (m_cnt + 1) % (1 << RW);
        if (m_rounds != 0 && m_cnt == m_rounds) begin
          m_st = 3; m_done = 1;
        end
      end
    end
  endtask

  task automatic model_step();
    m_done = 0; m_abort = 0; m_err = 0;
    if (reset) begin
      m_st = 0; m_k = 0; m_raw = 0; m_cnt = 0; m_rounds = 0; m_arm = 0;
    end else if (SC && m_raw && !legal(m_rawq)) begin
      m_raw = 0; m_k = 0; m_err = 1;
    end else begin
      case (m_st)
        0: if (start && !stop) begin
             m_st = 1; m_rounds = int'(rounds); m_cnt = 0; m_k = 0; m_raw = 0; m_arm = 1;
           end
        1: if (stop) abort_run();
           else if (hold) m_st = 2;
           else if (m_arm) m_arm = 0;
           else advance();
        2: if (stop) abort_run();
           else if (!hold) m_st = 1;
        default: m_st = 0;
      endcase
    end
  endtask

  task automatic compare_all();
    check("Q", 32'(Q), 32'(exp_q()));
    check("phase", 32'(phase), 32'(exp_phase()));
    check("state", 32'(state), 32'(m_st));
    check("busy", 32'(busy), 32'(m_st == 1 || m_st == 2));
    check("round_cnt", 32'(round_cnt), 32'(m_cnt));
    check("done", 32'(done), 32'(m_done));
    check("aborted", 32'(aborted), 32'(m_abort));
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic edge_and_check();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic tick(input logic s_in, input logic p_in, input logic h_in);
    @(negedge clk);
    start = s_in; stop = p_in; hold = h_in;
    edge_and_check();
  endtask

  int  lat, busy_cnt;
  bit  seen, done_seen;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; rounds = '0;
    m_st = 0; m_k = 0; m_cnt = 0; m_rounds = 0; m_raw = 0; m_rawq = '0; m_arm = 0;

    // Reset for two edges, then release.
    tick(0, 0, 0);
    tick(0, 0, 0);
    reset = 1'b0;
    tick(0, 0, 0);
    check("reset_phase", 32'(phase), 32'h01);

    // Two rounds with no hold.
    rounds = 8'd2;
    tick(1, 0, 0);
    busy_cnt = busy ? 1 : 0;
    lat = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(0, 0, 0);
      lat++;
      if (lat == 9) check("round_cnt_after_8", 32'(round_cnt), 32'd1);
      if (done) seen = 1;
      else if (busy) busy_cnt++;
    end
    check("two_round_done_latency", 32'(lat), 32'd17);
    check("two_round_busy_cycles", 32'(busy_cnt), 32'd17);
    tick(0, 0, 0);
    check("two_round_idle", 32'(state), 32'd0);
    check("two_round_final_cnt", 32'(round_cnt), 32'd2);

    // One round with a 3-cycle hold at Q=1110.
    rounds = 8'd1;
    tick(1, 0, 0);
    lat = 0;
    for (int i = 0; i < 4; i++) begin tick(0, 0, 0); lat++; end
    check("hold_entry_q", 32'(Q), 32'b1110);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1); lat++;
      check("hold_q_frozen", 32'(Q), 32'b1110);
      check("hold_state_pause", 32'(state), 32'd2);
    end
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(0, 0, 0); lat++;
      if (done) seen = 1;
    end
    check("hold_done_latency", 32'(lat), 32'd13);
    tick(0, 0, 0);

    // Stop at Q=1111 in a three-round run, then start+stop together in IDLE.
    rounds = 8'd3;
    done_seen = 0;
    tick(1, 0, 0);
    for (int i = 0; i < 5; i++) begin tick(0, 0, 0); done_seen |= done; end
    check("stop_entry_q", 32'(Q), 32'b1111);
    tick(0, 1, 0);
    check("stop_q_zero", 32'(Q), 32'd0);
    check("stop_aborted", 32'(aborted), 32'd1);
    for (int i = 0; i < 3; i++) begin tick(0, 0, 0); done_seen |= done; end
    check("stop_no_done", 32'(done_seen), 32'd0);
    tick(1, 1, 0);
    check("start_stop_idle", 32'(state), 32'd0);

    // Continuous mode: 40 advances, then abort.
    rounds = 8'd0;
    done_seen = 0;
    tick(1, 0, 0);
    tick(0, 0, 0);
    for (int i = 0; i < 40; i++) begin tick(0, 0, 0); done_seen |= done; end
    check("cont_round_cnt_5", 32'(round_cnt), 32'd5);
    check("cont_no_done", 32'(done_seen), 32'd0);
    tick(0, 1, 0);
    check("cont_stop_aborted", 32'(aborted), 32'd1);

    // Continuous mode: 256 rounds wrap the round counter.
    tick(1, 0, 0);
    tick(0, 0, 0);
    for (int i = 0; i < 256*2*N; i++) tick(0, 0, 0);
    check("cont_wrap_cnt", 32'(round_cnt), 32'd0);
    check("cont_wrap_busy", 32'(busy), 32'd1);
    tick(0, 1, 0);

    // Mid-run reset.
    rounds = 8'd2;
    tick(1, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0);
    reset = 1'b1;
    tick(0, 0, 0);
    check("midreset_no_pulse", 32'({done, aborted}), 32'd0);
    reset = 1'b0;
    tick(0, 0, 0);

    // Illegal word planted mid-run.
    rounds = 8'd2;
    tick(1, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0);
    @(negedge clk);
    start = 1'b0; stop = 1'b0; hold = 1'b0;
    force dut.q_q = 4'b0101;
    #1;
    release dut.q_q;
    m_raw = 1; m_rawq = 4'b0101;
    edge_and_check();
    check("illegal_next_q", 32'(Q), SC ? 32'd0 : 32'b0010);
    check("illegal_err", 32'(err), SC ? 32'd1 : 32'd0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0);
    tick(0, 1, 0);
    tick(0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rounds = RW'($urandom_range(0, 3));
      tick(logic'($urandom_range(0, 9) == 0),
           logic'($urandom_range(0, 29) == 0),
           logic'($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
